// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes,
// and the bit-length helper used by transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int calc_l(input int f, input int br);
    return f / br;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-length counter: counts 0..L-1, wraps, pulses tick_o on L-1.
// Ports: clk, rst (sync, high), clr_i (sync clear), tick_o.
module uart_baud_cnt #(
  parameter int L   = 4,
  parameter int LCW = $clog2(L)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  logic [LCW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LCW'(L - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + LCW'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, N data bits MSB first, opt. parity, stop.
// Ports: clk, rst, d/valid/ready handshake in, tx serial line out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int F      = 50_000_000,
  parameter int BR     = 115_200,
  parameter int L      = calc_l(F, BR),
  parameter int LCW    = $clog2(L),
  parameter int N      = 8,
  parameter int PARITY = 0,
  parameter int STOP   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         valid,
  output logic         ready,
  output logic         tx
);

  // Counts data bits, then reused to count stop bits.
  localparam int BCW = $clog2(N + 1);

  uart_state_e    state_q, state_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           rdy_q, rdy_d;
  logic           accept;
  logic           tick;

  assign accept = valid & rdy_q;
  assign ready  = rdy_q;
  assign tx     = tx_q;

  uart_baud_cnt #(
    .L   (L),
    .LCW (LCW)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = d;
          par_d   = (PARITY == PAR_ODD) ? ~^d : ^d;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == BCW'(N - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          end else begin
            sh_d  = sh_q << 1;
            bit_d = bit_q + BCW'(1);
          end
        end
      end
      S_PAR: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == BCW'(STOP - 1)) state_d = S_IDLE;
          else bit_d = bit_q + BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they
    // change on the same edge as the state itself.
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[N-1];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations against a frame model,
// plus literal waveform checks for the documented scenarios.
module tb_uart_tx;

  localparam int L = 4;
  localparam int PARA[4] = '{0, 1, 2, 0};
  localparam int STP[4]  = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = 8'h00;
  logic       valid = 1'b0;
  logic [3:0] tx_w;
  logic [3:0] rdy_w;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  uart_tx #(.L(L), .N(8), .PARITY(PARA[0]), .STOP(STP[0])) u0 (
    .clk(clk), .rst(rst), .d(d), .valid(valid),
    .ready(rdy_w[0]), .tx(tx_w[0]));
  uart_tx #(.L(L), .N(8), .PARITY(PARA[1]), .STOP(STP[1])) u1 (
    .clk(clk), .rst(rst), .d(d), .valid(valid),
    .ready(rdy_w[1]), .tx(tx_w[1]));
  uart_tx #(.L(L), .N(8), .PARITY(PARA[2]), .STOP(STP[2])) u2 (
    .clk(clk), .rst(rst), .d(d), .valid(valid),
    .ready(rdy_w[2]), .tx(tx_w[2]));
  uart_tx #(.L(L), .N(8), .PARITY(PARA[3]), .STOP(STP[3])) u3 (
    .clk(clk), .rst(rst), .d(d), .valid(valid),
    .ready(rdy_w[3]), .tx(tx_w[3]));

  task automatic chk(input string nm, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame as a time-ordered bit list: fr[j] is the j-th bit on the line.
  function automatic logic [15:0] mk(input logic [7:0] w,
                                     input int par, input int stp);
    logic [15:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    for (int b = 0; b < 8; b++) fr[1+b] = w[7-b];
    if (par != 0) fr[9] = (^w) ^ (par == 2);
    if (stp < 1) fr = '0;
    return fr;
  endfunction

  function automatic int flen(input int i);
    return (1 + 8 + ((PARA[i] != 0) ? 1 : 0) + STP[i]) * L;
  endfunction

  bit          busy[4];
  int          k[4];
  logic [15:0] fr[4];
  logic        etx[4];
  logic        erdy[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      busy[i] = 0; k[i] = 0; fr[i] = '1;
      etx[i] = 1'b1; erdy[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        busy[i] = 0; etx[i] = 1'b1; erdy[i] = 1'b0;
      end else if (!busy[i]) begin
        if (valid && erdy[i]) begin
          busy[i] = 1; k[i] = 0;
          fr[i] = mk(d, PARA[i], STP[i]);
          etx[i] = 1'b0; erdy[i] = 1'b0;
        end else begin
          etx[i] = 1'b1; erdy[i] = 1'b1;
        end
      end else begin
        k[i]++;
        if (k[i] == flen(i)) begin
          busy[i] = 0; etx[i] = 1'b1; erdy[i] = 1'b1;
        end else begin
          etx[i] = fr[i][k[i] / L];
        end
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_tx%0d", i), tx_w[i], etx[i]);
      chk($sformatf("model_ready%0d", i), rdy_w[i], erdy[i]);
    end
  end

  task automatic wait_all_idle();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (rdy_w == 4'hF) return;
    end
    ncmp++; nfail++;
    $display("FAIL idle_timeout: ready=%b want 1111", rdy_w);
  endtask

  // Sends w and checks u0's line against literal bits eb (time order,
  // eb[9] first). Optionally injects d/valid or a reset mid-frame.
  task automatic frame0(input logic [7:0] w, input logic [9:0] eb,
                        input int inj, input int rst_at);
    d = w; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("midrst_tx", tx_w[0], 1'b1);
        chk("midrst_ready", rdy_w[0], 1'b0);
        rst = 1'b0;
        return;
      end
      if (c < 40) begin
        chk($sformatf("lit_bit_c%0d", c), tx_w[0], eb[9 - c / 4]);
        chk($sformatf("lit_busy_c%0d", c), rdy_w[0], 1'b0);
      end else begin
        chk("lit_ready_at40", rdy_w[0], 1'b1);
        chk("lit_idle_tx", tx_w[0], 1'b1);
      end
      if (c == inj) begin d = 8'h3C; valid = 1'b1; end
      if (c == inj + 1) valid = 1'b0;
      if (c == rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    logic [9:0] a5_bits;
    logic [9:0] b81_bits;
    a5_bits  = 10'b0_10100101_1;
    b81_bits = 10'b0_10000001_1;

    // Reset held three cycles.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_tx", tx_w[0], 1'b1);
      chk("rst_ready", rdy_w[0], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", rdy_w[0], 1'b1);

    // 0xA5, no parity, one stop bit.
    frame0(8'hA5, a5_bits, -1, -1);
    wait_all_idle();

    // 0x07: even parity bit 1, odd parity bit 0, 44-cycle frames.
    d = 8'h07; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 37) begin
        chk("even_par_bit", tx_w[1], 1'b1);
        chk("odd_par_bit", tx_w[2], 1'b0);
      end
      if (c == 43) begin
        chk("par_busy43_e", rdy_w[1], 1'b0);
        chk("par_busy43_o", rdy_w[2], 1'b0);
      end
      if (c == 44) begin
        chk("par_ready44_e", rdy_w[1], 1'b1);
        chk("par_ready44_o", rdy_w[2], 1'b1);
      end
    end
    wait_all_idle();

    // Two stop bits, back-to-back 0x00 then 0xFF with valid held.
    d = 8'h00; valid = 1'b1;
    @(posedge clk); #1;
    d = 8'hFF;
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 36 || c == 43) chk("stop2_high", tx_w[3], 1'b1);
      if (c == 43) chk("stop2_busy43", rdy_w[3], 1'b0);
      if (c == 44) begin
        chk("stop2_ready44", rdy_w[3], 1'b1);
        chk("stop2_tx44", tx_w[3], 1'b1);
      end
      if (c == 45) begin
        chk("b2b_start45", tx_w[3], 1'b0);
        chk("b2b_busy45", rdy_w[3], 1'b0);
        valid = 1'b0;
      end
    end
    wait_all_idle();

    // d/valid changes during data bit 2 are ignored.
    frame0(8'hA5, a5_bits, 13, -1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    chk("no_second_frame", tx_w[0], 1'b1);
    wait_all_idle();

    // Reset during data bit 3, then a clean 0x81 frame.
    frame0(8'hA5, a5_bits, -1, 17);
    wait_all_idle();
    frame0(8'h81, b81_bits, -1, -1);
    wait_all_idle();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; valid = 1'b0;
    wait_all_idle();
    @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts an N-bit parallel word over a valid/ready handshake and shifts it out on a single line as start bit, data bits MSB first, optional parity bit, and 1 or 2 stop bits. It is the transmit half of the team's UART link. Its framing, bit order and bit length are the same as the team's UART receiver's, so `q` at the far end equals the word loaded here.

## Interface
Reset is synchronous and active-high on `rst`; single clock `clk`.

Parameters:
- F, 50_000_000, main clock frequency in Hz
- BR, 115_200, bitrate in bit/s
- L, F/BR, clock cycles per bit; overridable directly, must be ≥ 2
- LCW, $clog2(L), bit-length counter width
- N, 8, data word width
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP, 1, number of stop bits, 1 or 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- d  in  N  word to send, sampled on accept
- valid  in  1  `d` is valid
- ready  out  1  transmitter idle, word accepted when `valid & ready`
- tx  out  1  serial line, idles high

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - `tx`=1 and `ready`=1.
  - On `valid & ready`: latch `d` into the shift register, compute the parity bit, clear counters, go to START.
- START: `tx`=0 for L cycles, then DATA.
- DATA:
  - `tx` = shift register MSB; shift left once every L cycles.
  - Bit counter runs 0..N-1.
  - After the N-th bit: go to PAR if PARITY≠0, else STOP.
- PAR: `tx` = parity bit for L cycles, then STOP.
  - Even parity = XOR of the N data bits.
  - Odd parity = inverse of that XOR.
- STOP: `tx`=1 for STOP×L cycles, then IDLE.
- Bit-length counter: LCW bits, counts 0..L-1 and wraps. The bit/state advances on the wrap cycle (count = L-1).
- `d` and `valid` are ignored outside IDLE. Changing `d` after accept has no effect on the frame.
- `tx` and `ready` are registered outputs: no combinational path from any input.

## Timing
- Reset values, applied on any rising edge with `rst`=1: state=IDLE, `tx`=1, `ready`=0, counters=0, shift register=0.
- First edge with `rst`=0: `ready`=1.
- Accept edge (call it edge 0):
  - `ready`=0 and `tx`=0 from edge 0.
  - Start bit occupies edges 0..L-1; each following bit is exactly L cycles.
- Frame length FB = 1 + N + (PARITY≠0) + STOP bits.
- Return to idle: `ready` returns to 1 at edge FB×L, the same edge that ends the last stop bit. `tx` stays 1.
- Back-to-back with `valid` held high: the next accept occurs at edge FB×L. The next start bit begins on the following edge, so frame period = FB×L + 1 cycles.
- `valid` asserted while `ready`=0: no effect and no queueing. The source holds `valid` until it sees `ready`.
- Reset mid-frame: the next edge forces `tx`=1 and `ready`=0. The partial frame is abandoned and no bits are resumed after release.
- Reset dominates a simultaneous `valid & ready`.

## Structure
- Shared UART package holds:
  - the state encoding (IDLE..STOP, 3 bits), also usable by the receiver;
  - PARITY encoding constants (NONE=0, EVEN=1, ODD=2);
  - a function computing L from F and BR.
- Natural sub-module `uart_baud_cnt`:
  - L-cycle counter with synchronous clear and a one-cycle `tick` on wrap;
  - reusable by the receiver.
- FSM, shift register and parity logic stay in `uart_tx`.

## Test plan
All cases use L=4, N=8 unless stated.
- Reset: hold `rst`=1 for 3 cycles → `tx`=1, `ready`=0 throughout; `ready`=1 on the first edge after release.
- 0xA5, PARITY=0, STOP=1:
  - `tx` = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles;
  - `ready` rises 40 cycles after the accept edge.
- 0x07 with PARITY=1 → parity bit 1; with PARITY=2 → parity bit 0. Frame is 44 cycles in both cases.
- STOP=2, words 0x00 then 0xFF with `valid` held:
  - stop high for 8 cycles;
  - second start bit begins exactly 1 cycle after `ready` rises;
  - frame period 45 cycles.
- Change `d` to 0x3C and pulse `valid` during data bit 2 of a 0xA5 frame → transmitted bits are unchanged and no second frame starts.
- Assert `rst` for 1 cycle during data bit 3 → `tx`=1 on the next edge; a following frame of 0x81 is transmitted correctly.
